lcd_ctrl: RTL and testbench

- Consumes the processor's o_io_lcd register word and drives an HD44780-compatible character LCD bus with correct setup, enable-pulse, hold and execution timing.
- Software writes commands and characters through the existing LCD I/O register. The block queues them in a small command FIFO and sequences each one onto the pins, so firmware never bit-bangs timing.
- Sits directly downstream of the pipelined core's LSU/MEM-WB I/O outputs, at the top level.

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_cmd_fifo.sv | 49 ++++
 rtl/lcd_ctrl.sv | 133 +++++++++++++
 tb/tb_lcd_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD bus sequencer.
// Bit positions refer to the processor's LCD I/O register word.
package lcd_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} lcd_state_e;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_BLON_BIT = 30;
  localparam int LCD_TGL_BIT  = 10;
  localparam int LCD_RS_BIT   = 8;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(lcd_cmd_t cmd);
    return !cmd.rs && (cmd.data[7:2] == 6'd0) && (cmd.data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command queue between register writes and the bus sequencer.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module lcd_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 bus sequencer: captures TGL-marked writes from the LCD I/O register,
// queues them, and plays each out with setup / enable / hold / execution timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int EN_PULSE_CYC   = 12,
  parameter int HOLD_CYC       = 2,
  parameter int EXEC_CYC       = 2000,
  parameter int CLEAR_EXEC_CYC = 82000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_lcd_blon,
  output logic        o_busy,
  output logic        o_full,
  output logic        o_overflow
);
  localparam int MAX_CYC = (CLEAR_EXEC_CYC > EXEC_CYC) ? CLEAR_EXEC_CYC : EXEC_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  logic [31:0]                  lcd_q;
  logic                         tgl_prev;
  logic                         evt, push, pop, empty, full;
  logic [$clog2(FIFO_DEPTH):0]  count;
  lcd_cmd_t                     cmd_in, cmd_out;

  lcd_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       data_n;
  logic             rs_n, en_n;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lcd_q    <= '0;
      tgl_prev <= 1'b0;
    end else begin
      lcd_q    <= i_io_lcd;
      tgl_prev <= lcd_q[LCD_TGL_BIT];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lcd_q[29:11], lcd_q[9]};

  assign o_lcd_on   = lcd_q[LCD_ON_BIT];
  assign o_lcd_blon = lcd_q[LCD_BLON_BIT];
  assign o_lcd_rw   = 1'b0;

  assign evt    = lcd_q[LCD_TGL_BIT] != tgl_prev;
  assign cmd_in = '{rs: lcd_q[LCD_RS_BIT], data: lcd_q[7:0]};
  assign push   = evt;

  lcd_cmd_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_in),
    .rdata (cmd_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign o_full = full;
  assign o_busy = (state != IDLE) || (count != '0);

  // Dropped only when the queue stays full through this cycle (no pop frees a slot).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                    o_overflow <= 1'b0;
    else if (evt && full && !pop)   o_overflow <= 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      o_lcd_data <= '0;
      o_lcd_rs   <= 1'b0;
      o_lcd_en   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      o_lcd_data <= data_n;
      o_lcd_rs   <= rs_n;
      o_lcd_en   <= en_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = o_lcd_data;
    rs_n    = o_lcd_rs;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty && lcd_q[LCD_ON_BIT]) begin
        pop     = 1'b1;
        data_n  = cmd_out.data;
        rs_n    = cmd_out.rs;
        cnt_n   = CNT_W'(SETUP_CYC - 1);
        state_n = SETUP;
      end
      SETUP: if (cnt == '0) begin
        cnt_n   = CNT_W'(EN_PULSE_CYC - 1);
        state_n = PULSE;
      end else cnt_n = cnt - 1'b1;
      PULSE: if (cnt == '0) begin
        cnt_n   = CNT_W'(HOLD_CYC - 1);
        state_n = HOLD;
      end else cnt_n = cnt - 1'b1;
      HOLD: if (cnt == '0) begin
        cnt_n   = is_long_cmd('{rs: o_lcd_rs, data: o_lcd_data})
                  ? CNT_W'(CLEAR_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
        state_n = EXEC;
      end else cnt_n = cnt - 1'b1;
      EXEC: if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
    // Registered from the next state so EN changes only on clock edges.
    en_n = (state_n == PULSE);
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing (2/4/2/10/50, depth 4).
module tb_lcd_ctrl;
  localparam int SETUP = 2, PULSE = 4, HOLD = 2, EXEC = 10, CLEAR = 50, DEPTH = 4;
  localparam int NORM_BUSY = 1 + SETUP + PULSE + HOLD + EXEC;
  localparam int LONG_BUSY = 1 + SETUP + PULSE + HOLD + CLEAR;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_lcd;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, full, overflow;

  lcd_ctrl #(
    .SETUP_CYC(SETUP), .EN_PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
    .EXEC_CYC(EXEC), .CLEAR_EXEC_CYC(CLEAR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_io_lcd(io_lcd),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en),
    .o_lcd_on(lcd_on), .o_lcd_blon(lcd_blon), .o_busy(busy), .o_full(full),
    .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Records the data bus at every EN rising edge, and any RW activity.
  logic       en_prev = 1'b0;
  int         pulses  = 0;
  logic [7:0] seen_q[$];
  logic       rw_seen = 1'b0;
  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      pulses <= pulses + 1;
      seen_q.push_back(lcd_data);
    end
    en_prev <= lcd_en;
    if (lcd_rw !== 1'b0) rw_seen <= 1'b1;
  end

  typedef struct {
    logic [31:0] word;
    logic [7:0]  e_data;
    logic        e_rs;
    int          e_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic toggle_in(input logic [31:0] w);
    io_lcd = {w[31:11], ~io_lcd[10], w[9:0]};
  endtask

  task automatic run_vec(input int i);
    int busy_n = 0, en_n = 0, pre_n = 0;
    bit done = 0;
    @(negedge clk);
    toggle_in(vecs[i].word);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        if (lcd_en) en_n++;
        else if (en_n == 0) pre_n++;
      end else if (busy_n > 0) done = 1;
    end
    chk($sformatf("v%0d done", i), 32'(done), 32'd1);
    chk($sformatf("v%0d busy_cycles", i), busy_n, vecs[i].e_busy);
    chk($sformatf("v%0d en_cycles", i), en_n, PULSE);
    chk($sformatf("v%0d pre_en_cycles", i), pre_n, 1 + SETUP);
    chk($sformatf("v%0d data", i), lcd_data, vecs[i].e_data);
    chk($sformatf("v%0d rs", i), lcd_rs, vecs[i].e_rs);
    chk($sformatf("v%0d on", i), lcd_on, vecs[i].word[31]);
    chk($sformatf("v%0d blon", i), lcd_blon, vecs[i].word[30]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " en"}, lcd_en, 0);
    chk({tag, " data"}, lcd_data, 0);
    chk({tag, " rs"}, lcd_rs, 0);
    chk({tag, " rw"}, lcd_rw, 0);
    chk({tag, " on"}, lcd_on, 0);
    chk({tag, " blon"}, lcd_blon, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " full"}, full, 0);
    chk({tag, " overflow"}, overflow, 0);
  endtask

  initial begin
    int base, busy_seen;
    bit done;

    vecs[0] = '{32'h8000_0141, 8'h41, 1'b1, NORM_BUSY};
    vecs[1] = '{32'h8000_0001, 8'h01, 1'b0, LONG_BUSY};
    vecs[2] = '{32'h8000_0038, 8'h38, 1'b0, NORM_BUSY};
    vecs[3] = '{32'h8000_0002, 8'h02, 1'b0, LONG_BUSY};
    vecs[4] = '{32'h8000_0003, 8'h03, 1'b0, LONG_BUSY};
    vecs[5] = '{32'h8000_0004, 8'h04, 1'b0, NORM_BUSY};
    vecs[6] = '{32'h8000_0000, 8'h00, 1'b0, NORM_BUSY};
    vecs[7] = '{32'h8000_0101, 8'h01, 1'b1, NORM_BUSY};
    vecs[8] = '{32'hC000_0141, 8'h41, 1'b1, NORM_BUSY};

    reset  = 1'b1;
    io_lcd = 32'h0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // DATA rewrites without a TGL change must not start a transaction.
    @(negedge clk);
    io_lcd = {io_lcd[31:8], 8'h55};
    repeat (3) @(negedge clk);
    io_lcd = {io_lcd[31:8], 8'h66};
    base = pulses;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("rewrite busy", busy_seen, 0);
    chk("rewrite pulses", pulses - base, 0);

    // Queue five commands with the panel off: the fifth is dropped.
    base = pulses;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      toggle_in({1'b0, 22'h0, 1'b0, 1'b1, 8'(8'h10 + k)});
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("ovf full", full, 1);
    chk("ovf overflow", overflow, 1);
    chk("ovf busy", busy, 1);
    chk("ovf no pulses", pulses - base, 0);
    io_lcd[31] = 1'b1;
    done = 0;
    for (int c = 0; c < 4 * NORM_BUSY + 40 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    chk("ovf drained", 32'(done), 1);
    chk("ovf pulse count", pulses - base, 4);
    for (int k = 0; k < 4; k++)
      if (base + k < seen_q.size())
        chk($sformatf("ovf order %0d", k), seen_q[base + k], 32'(8'h10 + k));
    chk("ovf sticky", overflow, 1);
    chk("ovf not full", full, 0);

    // Two queued commands, then reset in the middle of the first EN pulse.
    @(negedge clk);
    toggle_in(32'h8000_0121);
    @(negedge clk);
    @(negedge clk);
    toggle_in(32'h8000_0122);
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (lcd_en) done = 1;
    end
    chk("midpulse en seen", 32'(done), 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("midpulse reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = pulses;
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("post reset pulses", pulses - base, 0);
    chk("post reset busy", busy_seen, 0);
    chk("post reset on", lcd_on, 1);
    chk("rw never driven", rw_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
